// File: rtl/if_fetch_buf_pkg.sv
// Shared constants and types for the instruction fetch buffer.
// Entries carry the fetch address next to the returned word so decode sees both.
package if_fetch_buf_pkg;

  localparam int          IBUS_ADDR_W      = 32;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef struct packed {
    logic [IBUS_ADDR_W-1:0] addr;
    logic [31:0]            data;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf_fifo.sv
// Small FIFO with a combinational head view; clear wins over push and pop.
// Pointers wrap naturally because the depth is a power of two.
module if_fetch_buf_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/if_fetch_buf.sv
// Fetch stage: one outstanding single-beat read, responses buffered for decode.
// stallreq_o drops only in the cycle a request is accepted, so pc_reg advances once per fetch.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IBUS_ADDR_W-1:0] pc_i,
  input  logic                   ce_i,
  input  logic                   ex_branch_flag_i,
  input  logic [4:0]             stalled_i,
  output logic                   stallreq_o,
  output logic                   ibus_req_o,
  output logic [IBUS_ADDR_W-1:0] ibus_addr_o,
  input  logic                   ibus_gnt_i,
  input  logic                   ibus_rvalid_i,
  input  logic [31:0]            ibus_rdata_i,
  output logic [31:0]            inst_o,
  output logic [IBUS_ADDR_W-1:0] inst_addr_o,
  output logic                   inst_valid_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [0:0]             state_reg;
  logic [IBUS_ADDR_W-1:0] pend_addr_reg;
  logic                   discard_reg;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          in_wait;
  logic          space;
  logic          req;
  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          unused_stall_bits;

  assign unused_stall_bits = ^{stalled_i[4:2], stalled_i[0]};

  assign in_wait   = (state_reg == ST_WAIT);
  // The outstanding request reserves a slot so its response always fits.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, in_wait};
  assign space     = occupancy < (CW + 1)'(FIFO_DEPTH);

  assign resp   = in_wait && ibus_rvalid_i;
  assign req    = !rst && ce_i && space && !ex_branch_flag_i && (!in_wait || ibus_rvalid_i);
  assign accept = req && ibus_gnt_i;

  assign push = resp && !discard_reg && !ex_branch_flag_i;
  assign pop  = inst_valid_o && !stalled_i[1] && !ex_branch_flag_i;

  assign push_entry.addr = pend_addr_reg;
  assign push_entry.data = ibus_rdata_i;

  if_fetch_buf_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .clear(ex_branch_flag_i),
    .din  (push_entry),
    .count(count),
    .head (head_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pend_addr_reg <= '0;
      discard_reg   <= 1'b0;
    end else begin
      if (accept) begin
        state_reg     <= ST_WAIT;
        pend_addr_reg <= pc_i;
      end else if (resp) begin
        state_reg <= ST_IDLE;
      end
      // A branch while a read is in flight poisons that read's response.
      if (resp) begin
        discard_reg <= 1'b0;
      end else if (ex_branch_flag_i && in_wait) begin
        discard_reg <= 1'b1;
      end
    end
  end

  assign ibus_req_o   = req;
  assign ibus_addr_o  = pc_i;
  assign stallreq_o   = !accept;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? head_entry.data : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? head_entry.addr : '0;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed per-cycle vectors for if_fetch_buf: each row drives one cycle's inputs
// and lists the combinational outputs expected during that cycle.
module tb_if_fetch_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        ex_branch_flag_i;
  logic [4:0]  stalled_i;
  logic        stallreq_o;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  if_fetch_buf dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .ce_i            (ce_i),
    .ex_branch_flag_i(ex_branch_flag_i),
    .stalled_i       (stalled_i),
    .stallreq_o      (stallreq_o),
    .ibus_req_o      (ibus_req_o),
    .ibus_addr_o     (ibus_addr_o),
    .ibus_gnt_i      (ibus_gnt_i),
    .ibus_rvalid_i   (ibus_rvalid_i),
    .ibus_rdata_i    (ibus_rdata_i),
    .inst_o          (inst_o),
    .inst_addr_o     (inst_addr_o),
    .inst_valid_o    (inst_valid_o)
  );

  typedef struct {
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        br;
    logic [4:0]  stall;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        req;
    logic        sreq;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] iaddr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [4:0]  ID  = 5'b00010;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
  endtask

  task automatic v(input logic r, input logic ce, input logic [31:0] pc, input logic br,
                   input logic [4:0] st, input logic gnt, input logic rv, input logic [31:0] rd,
                   input logic req, input logic sreq, input logic vld,
                   input logic [31:0] inst, input logic [31:0] iaddr);
    vec_t e;
    e.rst = r; e.ce = ce; e.pc = pc; e.br = br; e.stall = st; e.gnt = gnt; e.rv = rv;
    e.rd = rd; e.req = req; e.sreq = sreq; e.vld = vld; e.inst = inst; e.iaddr = iaddr;
    vecs.push_back(e);
  endtask

  initial begin
    //  rst ce  pc          br st  gnt rv  rdata           req sreq vld inst          iaddr
    v(1, 0, 32'h000, 0, 0,  0, 0, 32'h0,           0, 1, 0, NOP,          32'h000); // reset state
    // streaming fetch 0x0, 0x4, 0x8
    v(0, 1, 32'h000, 0, 0,  1, 0, 32'h0,           1, 0, 0, NOP,          32'h000);
    v(0, 1, 32'h004, 0, 0,  1, 1, 32'hC000_0000,   1, 0, 0, NOP,          32'h000);
    v(0, 1, 32'h008, 0, 0,  1, 1, 32'hC000_0004,   0, 1, 1, 32'hC000_0000, 32'h000);
    v(0, 1, 32'h008, 0, 0,  1, 0, 32'h0,           1, 0, 1, 32'hC000_0004, 32'h004);
    v(0, 0, 32'h00C, 0, 0,  1, 1, 32'hC000_0008,   0, 1, 0, NOP,          32'h000);
    v(0, 0, 32'h00C, 0, 0,  0, 0, 32'h0,           0, 1, 1, 32'hC000_0008, 32'h008);
    // decode stall: FIFO fills to two, then requests stop
    v(0, 1, 32'h010, 0, ID, 1, 0, 32'h0,           1, 0, 0, NOP,          32'h000);
    v(0, 1, 32'h014, 0, ID, 1, 1, 32'hC000_0010,   1, 0, 0, NOP,          32'h000);
    v(0, 1, 32'h018, 0, ID, 1, 1, 32'hC000_0014,   0, 1, 1, 32'hC000_0010, 32'h010);
    v(0, 1, 32'h018, 0, ID, 1, 0, 32'h0,           0, 1, 1, 32'hC000_0010, 32'h010);
    v(0, 1, 32'h018, 0, ID, 1, 0, 32'h0,           0, 1, 1, 32'hC000_0010, 32'h010);
    v(0, 1, 32'h018, 0, ID, 1, 0, 32'h0,           0, 1, 1, 32'hC000_0010, 32'h010);
    v(0, 1, 32'h018, 0, 0,  1, 0, 32'h0,           0, 1, 1, 32'hC000_0010, 32'h010);
    v(0, 1, 32'h018, 0, 0,  1, 0, 32'h0,           1, 0, 1, 32'hC000_0014, 32'h014);
    v(0, 0, 32'h01C, 0, 0,  1, 1, 32'hC000_0018,   0, 1, 0, NOP,          32'h000);
    v(0, 0, 32'h01C, 0, 0,  0, 0, 32'h0,           0, 1, 1, 32'hC000_0018, 32'h018);
    // grant withheld for three cycles
    v(0, 1, 32'h100, 0, 0,  0, 0, 32'h0,           1, 1, 0, NOP,          32'h000);
    v(0, 1, 32'h100, 0, 0,  0, 0, 32'h0,           1, 1, 0, NOP,          32'h000);
    v(0, 1, 32'h100, 0, 0,  0, 0, 32'h0,           1, 1, 0, NOP,          32'h000);
    v(0, 1, 32'h100, 0, 0,  1, 0, 32'h0,           1, 0, 0, NOP,          32'h000);
    v(0, 0, 32'h104, 0, 0,  1, 1, 32'hC000_0100,   0, 1, 0, NOP,          32'h000);
    v(0, 0, 32'h104, 0, 0,  0, 0, 32'h0,           0, 1, 1, 32'hC000_0100, 32'h100);
    // branch while waiting; late 0xDEAD response must be dropped
    v(0, 1, 32'h200, 0, 0,  1, 0, 32'h0,           1, 0, 0, NOP,          32'h000);
    v(0, 1, 32'h300, 1, 0,  1, 0, 32'h0,           0, 1, 0, NOP,          32'h000);
    v(0, 1, 32'h300, 0, 0,  1, 0, 32'h0,           0, 1, 0, NOP,          32'h000);
    v(0, 1, 32'h300, 0, 0,  1, 1, 32'h0000_DEAD,   1, 0, 0, NOP,          32'h000);
    v(0, 0, 32'h304, 0, 0,  1, 1, 32'hC000_0300,   0, 1, 0, NOP,          32'h000);
    v(0, 0, 32'h304, 0, 0,  0, 0, 32'h0,           0, 1, 1, 32'hC000_0300, 32'h300);
    // branch coinciding with rvalid and a pop at count=1
    v(0, 1, 32'h400, 0, 0,  1, 0, 32'h0,           1, 0, 0, NOP,          32'h000);
    v(0, 1, 32'h404, 0, ID, 1, 1, 32'hC000_0400,   1, 0, 0, NOP,          32'h000);
    v(0, 1, 32'h500, 1, 0,  1, 1, 32'hC000_0404,   0, 1, 1, 32'hC000_0400, 32'h400);
    v(0, 0, 32'h500, 0, 0,  0, 0, 32'h0,           0, 1, 0, NOP,          32'h000);
    // simultaneous push and pop at count=1, then reset mid-WAIT
    v(0, 1, 32'h600, 0, 0,  1, 0, 32'h0,           1, 0, 0, NOP,          32'h000);
    v(0, 1, 32'h604, 0, ID, 1, 1, 32'hC000_0600,   1, 0, 0, NOP,          32'h000);
    v(0, 0, 32'h608, 0, 0,  1, 1, 32'hC000_0604,   0, 1, 1, 32'hC000_0600, 32'h600);
    v(0, 0, 32'h608, 0, ID, 0, 0, 32'h0,           0, 1, 1, 32'hC000_0604, 32'h604);
    v(0, 1, 32'h700, 0, ID, 1, 0, 32'h0,           1, 0, 1, 32'hC000_0604, 32'h604);
    v(1, 0, 32'h700, 0, ID, 0, 0, 32'h0,           0, 1, 1, 32'hC000_0604, 32'h604);
    v(0, 0, 32'h700, 0, 0,  0, 0, 32'h0,           0, 1, 0, NOP,          32'h000);

    rst = 1'b1; ce_i = 1'b0; pc_i = '0; ex_branch_flag_i = 1'b0; stalled_i = '0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      #2;
      rst              = vecs[i].rst;
      ce_i             = vecs[i].ce;
      pc_i             = vecs[i].pc;
      ex_branch_flag_i = vecs[i].br;
      stalled_i        = vecs[i].stall;
      ibus_gnt_i       = vecs[i].gnt;
      ibus_rvalid_i    = vecs[i].rv;
      ibus_rdata_i     = vecs[i].rd;
      #2;
      check($sformatf("c%0d req", i),       {31'b0, ibus_req_o},   {31'b0, vecs[i].req});
      check($sformatf("c%0d stallreq", i),  {31'b0, stallreq_o},   {31'b0, vecs[i].sreq});
      check($sformatf("c%0d valid", i),     {31'b0, inst_valid_o}, {31'b0, vecs[i].vld});
      check($sformatf("c%0d inst", i),      inst_o,                vecs[i].inst);
      check($sformatf("c%0d inst_addr", i), inst_addr_o,           vecs[i].iaddr);
      check($sformatf("c%0d bus_addr", i),  ibus_addr_o,           vecs[i].pc);
      $display("cycle %0d: req=%0b stallreq=%0b valid=%0b inst=%08h addr=%08h",
               i, ibus_req_o, stallreq_o, inst_valid_o, inst_o, inst_addr_o);
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_buf.md
Name: if_fetch_buf

Overview:
- Instruction fetch stage between pc_reg and the if_id/decode boundary.
- Takes the current PC and issues single-beat reads on the instruction bus, one outstanding at a time.
- Buffers the returned words in a small FIFO and presents {inst, inst_addr, valid} to decode.
- Drives stall back to ctrl so that pc_reg advances only when a fetch request is accepted. Flushes on an ex-stage branch.

Parameters:
- FIFO_DEPTH, 2, number of buffered instruction entries (power of two, >=2).
- NOP_INST, 32'h00000013, value driven on inst_o when no valid entry (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- pc_i  in  32  current PC from pc_reg
- ce_i  in  1  fetch enable from pc_reg
- ex_branch_flag_i  in  1  branch taken in ex; flush
- stalled_i  in  5  ctrl stall vector; bit1 = decode stall
- stallreq_o  out  1  to ctrl; high = pc_reg must hold
- ibus_req_o  out  1  bus address-phase request
- ibus_addr_o  out  32  bus address, equal to pc_i
- ibus_gnt_i  in  1  address phase accepted
- ibus_rvalid_i  in  1  read data valid
- ibus_rdata_i  in  32  read data
- inst_o  out  32  instruction to decode
- inst_addr_o  out  32  PC of inst_o
- inst_valid_o  out  1  inst_o holds a real fetched instruction

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, count=0, state IDLE, discard=0. Outputs: inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, ibus_req_o=0, stallreq_o=1.
- FSM:
  - IDLE: no outstanding request.
  - WAIT: request granted, awaiting rvalid.
- space = (count + (state==WAIT)) < FIFO_DEPTH.
- ibus_req_o = ce_i & space & !ex_branch_flag_i & (state==IDLE | (state==WAIT & ibus_rvalid_i)).
  - Back-to-back issue is allowed in the rvalid cycle.
  - ibus_addr_o = pc_i, combinational.
- Handshake:
  - Request accepted when ibus_req_o & ibus_gnt_i. Next state is WAIT, and the issued address is latched as pend_addr.
  - req and addr stay stable until gnt.
- stallreq_o = !(ibus_req_o & ibus_gnt_i). pc_reg therefore advances exactly once per accepted request.
  - A branch overrides stall inside pc_reg, so flush cycles need no special stall.
- Response in WAIT with ibus_rvalid_i=1:
  - Push {ibus_rdata_i, pend_addr} unless discard=1 or ex_branch_flag_i=1.
  - Clear discard.
  - Go to IDLE unless a new request was accepted in the same cycle.
- Pop:
  - A pop occurs when inst_valid_o=1 & stalled_i[1]=0.
  - Head is shown combinationally: inst_valid_o=(count!=0), inst_o=head data or NOP_INST, inst_addr_o=head addr or 0.
- Simultaneous push and pop: count unchanged, pointers both advance. Push into a full FIFO cannot occur because of the space rule.
- Flush (ex_branch_flag_i=1):
  - FIFO is cleared next cycle (count=0, pointers=0).
  - No request is issued that cycle.
  - If state==WAIT and rvalid is not in this cycle, set discard=1 so the in-flight response is dropped.
  - A pop in the flush cycle is ignored.
- Stall from ctrl on the ID bit only blocks pop. Fetching continues until the FIFO fills.
- Widths: count is $clog2(FIFO_DEPTH+1) bits. Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Reset mid-operation discards the FIFO and the outstanding state. The instruction bus is reset on the same rst, so no stale rvalid follows.

Decomposition:
- yadan_defs.v gains: NOP_INST value and IBUS_ADDR_W.
- Reuse the existing RstEnable, NoStop and BranchEnable macros; do not redefine them.
- One natural sub-module: if_fifo (parameterised depth, width 64 {addr,data}, push/pop/clear, count, head).

Test Plan:
- Reset then ce_i=1, gnt and rvalid always 1, pc_i=0x0,0x4,0x8 -> one req per cycle; inst_valid_o rises 2 cycles after the first req; inst_o/inst_addr_o in order 0x0,0x4,0x8.
- stalled_i[1]=1 for 6 cycles -> FIFO fills to 2, then ibus_req_o=0, stallreq_o=1. Release -> pops resume, no duplicates or drops.
- gnt held low 3 cycles with pc_i=0x100 -> ibus_req_o/addr stable at 0x100, stallreq_o=1 throughout, one accepted request.
- Branch in WAIT with rvalid 2 cycles later (data 0xDEAD) -> FIFO empty next cycle, 0xDEAD discarded. First valid output is the branch target's word.
- Branch in the same cycle as rvalid and pop at count=1 -> count=0 next cycle, response dropped, no req that cycle.
- Push and pop in the same cycle at count=1 -> count stays 1 and order is preserved. Assert rst mid-WAIT -> all outputs at reset values next cycle.
